// File: rtl/logger_pkg.sv
// Shared definitions for the multi-channel event logger: controller states,
// log entry field layout and drop counter helpers.
package logger_pkg;

  typedef enum logic [1:0] {
    ST_READY    = 2'd0,
    ST_CLEARING = 2'd1,
    ST_FULL     = 2'd2
  } log_state_e;

  // Entry layout: {payload, 24'b0, channel[7:0], timestamp[31:0]}
  localparam int TS_LSB        = 0;
  localparam int TS_BITW       = 32;
  localparam int CHAN_LSB      = 32;
  localparam int CHAN_BITW     = 8;
  localparam int PAD_LSB       = 40;
  localparam int PAD_BITW      = 24;
  localparam int PAYLOAD_LSB   = 64;
  localparam int HDR_BITW      = 64;

  localparam int DROP_CNT_BITW = 16;

  // Saturating add for the drop counter; several channels may drop in one cycle.
  function automatic logic [DROP_CNT_BITW-1:0] drop_sat_add(
    input logic [DROP_CNT_BITW-1:0] a,
    input logic [DROP_CNT_BITW-1:0] b
  );
    logic [DROP_CNT_BITW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[DROP_CNT_BITW]) begin
      return {DROP_CNT_BITW{1'b1}};
    end else begin
      return sum[DROP_CNT_BITW-1:0];
    end
  endfunction

endpackage

// File: rtl/sdp_bram.sv
// Simple dual-port block RAM: one write port, one registered read-first read
// port. Contents are intentionally not reset.
module sdp_bram #(
  parameter int ADDR_BITW = 4,
  parameter int DATA_BITW = 96
) (
  input  logic                 Clk_CI,
  input  logic                 WrEn_SI,
  input  logic [ADDR_BITW-1:0] WrAddr_DI,
  input  logic [DATA_BITW-1:0] WrData_DI,
  input  logic [ADDR_BITW-1:0] RdAddr_DI,
  output logic [DATA_BITW-1:0] RdData_DO
);

  logic [DATA_BITW-1:0] mem_r [2**ADDR_BITW];

  // Write port.
  always_ff @(posedge Clk_CI) begin
    if (WrEn_SI) begin
      mem_r[WrAddr_DI] <= WrData_DI;
    end
  end

  // Registered read; a same-edge write to the address returns the old word.
  always_ff @(posedge Clk_CI) begin
    RdData_DO <= mem_r[RdAddr_DI];
  end

endmodule

// File: rtl/multi_chan_logger.sv
// Multi-channel event logger: per-channel one-entry pending registers feed a
// round-robin arbiter that appends timestamped entries into a block RAM log,
// with ring / stop-when-full modes and a full-memory clear sequence.
module multi_chan_logger
  import logger_pkg::*;
#(
  parameter int NUM_CHANNELS  = 4,
  parameter int LOG_DATA_BITW = 32,
  parameter int NUM_ENTRIES   = 16384,
  parameter int FULL_MARGIN   = 1024
) (
  input  logic                                    Clk_CI,
  input  logic                                    Rst_RI,
  input  logic [NUM_CHANNELS*LOG_DATA_BITW-1:0]   LogData_DI,
  input  logic [NUM_CHANNELS-1:0]                 LogTrigger_SI,
  input  logic                                    LogEn_SI,
  input  logic                                    Clear_SI,
  input  logic                                    Wrap_SI,
  input  logic [$clog2(NUM_ENTRIES)-1:0]          RdAddr_SI,
  output logic [64+LOG_DATA_BITW-1:0]             RdData_DO,
  output logic                                    Full_SO,
  output logic                                    Ready_SO,
  output logic                                    Wrapped_SO,
  output logic [$clog2(NUM_ENTRIES):0]            EntryCnt_DO,
  output logic [$clog2(NUM_ENTRIES)-1:0]          WrPtr_DO,
  output logic [DROP_CNT_BITW-1:0]                DropCnt_DO
);

  localparam int AW         = $clog2(NUM_ENTRIES);
  localparam int ENTRY_BITW = HDR_BITW + LOG_DATA_BITW;
  localparam int CW         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  localparam logic [AW:0]   CNT_MAX  = (AW+1)'(NUM_ENTRIES);
  localparam logic [AW:0]   FULL_THR = (AW+1)'(NUM_ENTRIES - FULL_MARGIN);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_ENTRIES - 1);

  log_state_e                state_r, state_next_s;
  logic [31:0]               ts_r;
  logic [NUM_CHANNELS-1:0]   pend_r;
  logic [LOG_DATA_BITW-1:0]  pend_data_r [NUM_CHANNELS];
  logic [31:0]               pend_ts_r   [NUM_CHANNELS];
  logic [CW-1:0]             last_grant_r, last_grant_next_s;
  logic [AW-1:0]             wr_ptr_r, wr_ptr_next_s;
  logic [AW-1:0]             clr_idx_r, clr_idx_next_s;
  logic [AW:0]               entry_cnt_r, entry_cnt_next_s;
  logic [DROP_CNT_BITW-1:0]  drop_cnt_r, drop_cnt_next_s, drop_inc_s;
  logic                      wrapped_r, wrapped_next_s;
  logic                      full_r, ready_r;

  logic                      clear_req_s, cnt_at_max_s, capture_ok_s;
  logic                      grant_found_s, grant_s;
  logic [CW-1:0]             grant_idx_s;
  logic [NUM_CHANNELS-1:0]   grant_vec_s, accept_vec_s, drop_vec_s;
  int                        cand_v;

  logic                      ram_we_s;
  logic [AW-1:0]             ram_waddr_s;
  logic [ENTRY_BITW-1:0]     ram_wdata_s;

  assign clear_req_s  = Clear_SI && (state_r != ST_CLEARING);
  assign cnt_at_max_s = (entry_cnt_r == CNT_MAX);
  assign capture_ok_s = LogEn_SI && (state_r != ST_CLEARING) && !Clear_SI;

  // Round-robin search for the first pending channel after the last grant.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = last_grant_r;
    cand_v        = 0;
    for (int i = 1; i <= NUM_CHANNELS; i++) begin
      cand_v = int'(last_grant_r) + i;
      if (cand_v >= NUM_CHANNELS) begin
        cand_v = cand_v - NUM_CHANNELS;
      end else begin
        cand_v = cand_v;
      end
      if (!grant_found_s && pend_r[cand_v]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = CW'(cand_v);
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Grant qualification: only in READY, not in a clear cycle, not when a
  // stop-mode log is already at capacity.
  assign grant_s = grant_found_s && (state_r == ST_READY) && !clear_req_s &&
                   !(cnt_at_max_s && !Wrap_SI);

  // Per-channel capture / drop decisions and the number of drops this cycle.
  always_comb begin
    grant_vec_s  = '0;
    accept_vec_s = '0;
    drop_vec_s   = '0;
    drop_inc_s   = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      grant_vec_s[c]  = grant_s && (grant_idx_s == CW'(c));
      accept_vec_s[c] = LogTrigger_SI[c] && capture_ok_s && (!pend_r[c] || grant_vec_s[c]);
      drop_vec_s[c]   = LogTrigger_SI[c] && capture_ok_s && pend_r[c] && !grant_vec_s[c];
      if (drop_vec_s[c]) begin
        drop_inc_s = drop_inc_s + 16'd1;
      end else begin
        drop_inc_s = drop_inc_s;
      end
    end
  end

  // Controller next state.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_READY: begin
        if (Clear_SI) begin
          state_next_s = ST_CLEARING;
        end else if (cnt_at_max_s && !Wrap_SI) begin
          state_next_s = ST_FULL;
        end else begin
          state_next_s = ST_READY;
        end
      end
      ST_FULL: begin
        if (Clear_SI) begin
          state_next_s = ST_CLEARING;
        end else if (Wrap_SI) begin
          state_next_s = ST_READY;
        end else begin
          state_next_s = ST_FULL;
        end
      end
      ST_CLEARING: begin
        if (clr_idx_r == LAST_IDX) begin
          state_next_s = ST_READY;
        end else begin
          state_next_s = ST_CLEARING;
        end
      end
      default: state_next_s = ST_READY;
    endcase
  end

  // Next values of the log bookkeeping counters and flags.
  always_comb begin
    wr_ptr_next_s     = wr_ptr_r;
    entry_cnt_next_s  = entry_cnt_r;
    drop_cnt_next_s   = drop_cnt_r;
    wrapped_next_s    = wrapped_r;
    last_grant_next_s = last_grant_r;
    clr_idx_next_s    = clr_idx_r;
    if (clear_req_s) begin
      wr_ptr_next_s     = '0;
      entry_cnt_next_s  = '0;
      drop_cnt_next_s   = '0;
      wrapped_next_s    = 1'b0;
      last_grant_next_s = '0;
      clr_idx_next_s    = '0;
    end else begin
      drop_cnt_next_s = drop_sat_add(drop_cnt_r, drop_inc_s);
      if (grant_s) begin
        wr_ptr_next_s     = wr_ptr_r + AW'(1'b1);
        entry_cnt_next_s  = cnt_at_max_s ? entry_cnt_r : entry_cnt_r + (AW+1)'(1'b1);
        last_grant_next_s = grant_idx_s;
        wrapped_next_s    = wrapped_r || ((wr_ptr_r == LAST_IDX) && (entry_cnt_next_s == CNT_MAX));
      end else begin
        wr_ptr_next_s = wr_ptr_r;
      end
      if (state_r == ST_CLEARING) begin
        clr_idx_next_s = clr_idx_r + AW'(1'b1);
      end else begin
        clr_idx_next_s = clr_idx_r;
      end
    end
  end

  // Free-running timestamp; only reset clears it.
  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      ts_r <= 32'd0;
    end else begin
      ts_r <= ts_r + 32'd1;
    end
  end

  // Pending occupancy bits: set on capture, cleared on grant or clear.
  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      pend_r <= '0;
    end else if (clear_req_s) begin
      pend_r <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (accept_vec_s[c]) begin
          pend_r[c] <= 1'b1;
        end else if (grant_vec_s[c]) begin
          pend_r[c] <= 1'b0;
        end
      end
    end
  end

  // Pending payload and timestamp holding registers (no reset needed).
  always_ff @(posedge Clk_CI) begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (accept_vec_s[c]) begin
        pend_data_r[c] <= LogData_DI[c*LOG_DATA_BITW +: LOG_DATA_BITW];
        pend_ts_r[c]   <= ts_r;
      end
    end
  end

  // Controller state, counters and registered status flags.
  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      state_r      <= ST_READY;
      wr_ptr_r     <= '0;
      entry_cnt_r  <= '0;
      drop_cnt_r   <= '0;
      wrapped_r    <= 1'b0;
      last_grant_r <= '0;
      clr_idx_r    <= '0;
      full_r       <= 1'b0;
      ready_r      <= 1'b1;
    end else begin
      state_r      <= state_next_s;
      wr_ptr_r     <= wr_ptr_next_s;
      entry_cnt_r  <= entry_cnt_next_s;
      drop_cnt_r   <= drop_cnt_next_s;
      wrapped_r    <= wrapped_next_s;
      last_grant_r <= last_grant_next_s;
      clr_idx_r    <= clr_idx_next_s;
      full_r       <= (entry_cnt_next_s >= FULL_THR) || (state_next_s == ST_FULL);
      ready_r      <= (state_next_s != ST_CLEARING);
    end
  end

  // RAM write source: zero fill while clearing, otherwise the granted entry.
  always_comb begin
    ram_we_s    = 1'b0;
    ram_waddr_s = wr_ptr_r;
    ram_wdata_s = '0;
    if (state_r == ST_CLEARING) begin
      ram_we_s    = 1'b1;
      ram_waddr_s = clr_idx_r;
    end else if (grant_s) begin
      ram_we_s = 1'b1;
      ram_wdata_s[TS_LSB +: TS_BITW]             = pend_ts_r[grant_idx_s];
      ram_wdata_s[CHAN_LSB +: CHAN_BITW]         = CHAN_BITW'(grant_idx_s);
      ram_wdata_s[PAD_LSB +: PAD_BITW]           = '0;
      ram_wdata_s[PAYLOAD_LSB +: LOG_DATA_BITW]  = pend_data_r[grant_idx_s];
    end else begin
      ram_we_s = 1'b0;
    end
  end

  sdp_bram #(
    .ADDR_BITW (AW),
    .DATA_BITW (ENTRY_BITW)
  ) u_log_ram (
    .Clk_CI    (Clk_CI),
    .WrEn_SI   (ram_we_s),
    .WrAddr_DI (ram_waddr_s),
    .WrData_DI (ram_wdata_s),
    .RdAddr_DI (RdAddr_SI),
    .RdData_DO (RdData_DO)
  );

  assign Full_SO     = full_r;
  assign Ready_SO    = ready_r;
  assign Wrapped_SO  = wrapped_r;
  assign EntryCnt_DO = entry_cnt_r;
  assign WrPtr_DO    = wr_ptr_r;
  assign DropCnt_DO  = drop_cnt_r;

endmodule
